// File: rtl/motoro_pkg.sv
// Shared types and constants for the motoro301 UART transmitter.
// Holds the transmitter state encoding, the system clock rate and a divider helper.
package motoro_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int MOTORO_CLK_HZ = 50_000_000;

    // Rounded clocks-per-bit for a given baud rate.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/motoro_sync_fifo.sv
// Single-clock byte FIFO with occupancy count; read data is the head entry (show-ahead),
// so a pop and its data are used on the same edge.
module motoro_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_ok, rd_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Full/empty come from the registered count, so a write into a full FIFO is
    // refused even when a pop happens on the same edge.
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/motoro_uart_tx.sv
// FIFO-fed 8N1 RS-232 transmitter for the rs232_tx pin of motoro301.
// Define MOTORO_UART_PARITY_EN to insert an even-parity bit (8E1 frames).
module motoro_uart_tx
    import motoro_pkg::*;
#(
    parameter int BAUD_DIV   = baud_div(MOTORO_CLK_HZ, 115200),
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk50mhz,
    input  logic                          nReset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          busy,
    output logic                          ovf,
    output logic                          rs232_tx
);

    localparam int             BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);

    uart_tx_state_t state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic           tx_q, tx_d;
    logic           ovf_q, ovf_d;
    logic           pop, bit_end;
    logic           fifo_empty;
    logic [7:0]     fifo_rd_data;
`ifdef MOTORO_UART_PARITY_EN
    logic           parity_q, parity_d;
`endif

    motoro_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk50mhz),
        .rst_n   (nReset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    assign bit_end = (baud_q == '0);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        pop       = 1'b0;

        if (state_q != IDLE) begin
            baud_d = bit_end ? BAUD_LAST : baud_q - BW'(1);
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_rd_data;
                    bit_cnt_d = 3'd0;
                    baud_d    = BAUD_LAST;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef MOTORO_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef MOTORO_UART_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                // Chain straight into the next start bit when more bytes are queued.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = fifo_rd_data;
                        bit_cnt_d = 3'd0;
                        state_d   = START;
                    end else begin
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MOTORO_UART_PARITY_EN
    assign parity_d = pop ? ^fifo_rd_data : parity_q;
`endif

    // Line level follows the state being entered, so it changes on the same edge.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_d[0];
`ifdef MOTORO_UART_PARITY_EN
            PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign ovf_d = ovf_q | (wr_en & full);

    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
`ifdef MOTORO_UART_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            baud_q    <= baud_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
`ifdef MOTORO_UART_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign rs232_tx = tx_q;
    assign ovf      = ovf_q;
    assign busy     = (state_q != IDLE) | (fifo_cnt != '0);

endmodule

// File: tb/tb_motoro_uart_tx.sv
// Directed self-checking bench for motoro_uart_tx at BAUD_DIV=4, FIFO_DEPTH=4.
// Frame expectations follow MOTORO_UART_PARITY_EN (8N1 or 8E1).
module tb_motoro_uart_tx;

    localparam int BD    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef MOTORO_UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB * BD;

    logic          clk50mhz = 1'b0;
    logic          nReset   = 1'b0;
    logic          wr_en    = 1'b0;
    logic [7:0]    wr_data  = 8'h00;
    logic          full, busy, ovf, rs232_tx;
    logic [CW-1:0] fifo_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    // Per-cycle stimulus and recorded outputs (index c = sample after the edge that takes write c)
    logic          wr_vld  [0:511];
    logic [7:0]    wr_dat  [0:511];
    logic          rec_tx  [0:511];
    logic          rec_busy[0:511];
    logic          rec_full[0:511];
    logic          rec_ovf [0:511];
    logic [CW-1:0] rec_cnt [0:511];

    logic [7:0]    dec_byte [0:15];
    int            dec_start[0:15];
    logic          dec_stop [0:15];
    logic          dec_par  [0:15];
    int            dec_n;

    motoro_uart_tx #(
        .BAUD_DIV   (BD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk50mhz (clk50mhz),
        .nReset   (nReset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .fifo_cnt (fifo_cnt),
        .busy     (busy),
        .ovf      (ovf),
        .rs232_tx (rs232_tx)
    );

    always #10 clk50mhz = ~clk50mhz;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (FB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < 512; i++) begin
            wr_vld[i] = 1'b0;
            wr_dat[i] = 8'h00;
        end
    endtask

    task automatic run_stream(input int n);
        for (int c = 0; c < n; c++) begin
            wr_en   = wr_vld[c];
            wr_data = wr_dat[c];
            @(posedge clk50mhz);
            #1;
            rec_tx[c]   = rs232_tx;
            rec_busy[c] = busy;
            rec_full[c] = full;
            rec_ovf[c]  = ovf;
            rec_cnt[c]  = fifo_cnt;
        end
        wr_en = 1'b0;
    endtask

    // Mid-bit sampling UART receiver over the recorded line.
    task automatic decode(input int n);
        int i;
        dec_n = 0;
        i = 0;
        while (i + FL <= n) begin
            if (rec_tx[i] === 1'b0) begin
                if (dec_n < 16) begin
                    for (int k = 0; k < 8; k++) dec_byte[dec_n][k] = rec_tx[i + BD*(k+1) + 1];
                    dec_start[dec_n] = i;
                    dec_par[dec_n]   = rec_tx[i + BD*9 + 1];
                    dec_stop[dec_n]  = rec_tx[i + FL - 2];
                end
                dec_n++;
                i += FL;
            end else begin
                i++;
            end
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        wr_en  = 1'b0;
        repeat (3) @(posedge clk50mhz);
        #1;
        tests_run++;
        if (rs232_tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b want 1", rs232_tx); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++;
        if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b want 0", full); end
        tests_run++;
        if (fifo_cnt !== '0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", fifo_cnt); end
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        nReset = 1'b1;
        clear_stim();
        run_stream(100);
        for (int i = 0; i < 100; i++) begin
            tests_run++;
            if ({rec_tx[i], rec_busy[i], rec_cnt[i]} !== {1'b1, 1'b0, CW'(0)}) begin
                tests_failed++;
                $display("FAIL idle_cycle%0d: tx=%b busy=%b cnt=%0d want tx=1 busy=0 cnt=0",
                         i, rec_tx[i], rec_busy[i], rec_cnt[i]);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] b;
        b = 8'hA5;
        clear_stim();
        wr_vld[0] = 1'b1; wr_dat[0] = b;
        run_stream(FL + 6);
        tests_run++;
        if (rec_cnt[0] !== CW'(1)) begin tests_failed++; $display("FAIL single_cnt_after_write: got %0d want 1", rec_cnt[0]); end
        tests_run++;
        if (rec_tx[0] !== 1'b1) begin tests_failed++; $display("FAIL single_tx_after_write: got %b want 1", rec_tx[0]); end
        tests_run++;
        if (rec_cnt[1] !== CW'(0)) begin tests_failed++; $display("FAIL single_cnt_after_pop: got %0d want 0", rec_cnt[1]); end
        for (int j = 0; j < FL; j++) begin
            tests_run++;
            if (rec_tx[1+j] !== frame_bit(b, j / BD)) begin
                tests_failed++;
                $display("FAIL single_line_cycle%0d: got %b want %b", j, rec_tx[1+j], frame_bit(b, j / BD));
            end
        end
        tests_run++;
        if (rec_busy[FL] !== 1'b1) begin tests_failed++; $display("FAIL single_busy_last_stop: got %b want 1", rec_busy[FL]); end
        tests_run++;
        if (rec_busy[FL+1] !== 1'b0) begin tests_failed++; $display("FAIL single_busy_fall: got %b want 0", rec_busy[FL+1]); end
        tests_run++;
        if (rec_tx[FL+1] !== 1'b1) begin tests_failed++; $display("FAIL single_idle_after: got %b want 1", rec_tx[FL+1]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]    exp_b [0:2];
        logic [CW-1:0] peak;
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        clear_stim();
        for (int c = 0; c < 3; c++) begin wr_vld[c] = 1'b1; wr_dat[c] = exp_b[c]; end
        run_stream(3*FL + 8);
        peak = '0;
        for (int i = 0; i < 3*FL + 8; i++) if (rec_cnt[i] > peak) peak = rec_cnt[i];
        tests_run++;
        if (peak !== CW'(2)) begin tests_failed++; $display("FAIL b2b_cnt_peak: got %0d want 2", peak); end
        decode(3*FL + 8);
        tests_run++;
        if (dec_n !== 3) begin tests_failed++; $display("FAIL b2b_frames: got %0d want 3", dec_n); end
        for (int f = 0; f < 3; f++) begin
            tests_run++;
            if (dec_start[f] !== 1 + f*FL) begin tests_failed++; $display("FAIL b2b_start%0d: got %0d want %0d", f, dec_start[f], 1 + f*FL); end
            tests_run++;
            if (dec_byte[f] !== exp_b[f]) begin tests_failed++; $display("FAIL b2b_byte%0d: got %h want %h", f, dec_byte[f], exp_b[f]); end
            tests_run++;
            if (dec_stop[f] !== 1'b1) begin tests_failed++; $display("FAIL b2b_stop%0d: got %b want 1", f, dec_stop[f]); end
`ifdef MOTORO_UART_PARITY_EN
            tests_run++;
            if (dec_par[f] !== ^exp_b[f]) begin tests_failed++; $display("FAIL b2b_parity%0d: got %b want %b", f, dec_par[f], ^exp_b[f]); end
`endif
        end
        tests_run++;
        if (rec_busy[3*FL+1] !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy_end: got %b want 0", rec_busy[3*FL+1]); end
    endtask

    task automatic test_stop_edge_write();
        clear_stim();
        wr_vld[0]    = 1'b1; wr_dat[0]    = 8'h81;
        wr_vld[FL+1] = 1'b1; wr_dat[FL+1] = 8'h42;
        run_stream(2*FL + 8);
        tests_run++;
        if (rec_tx[FL] !== 1'b1) begin tests_failed++; $display("FAIL edge_last_stop: got %b want 1", rec_tx[FL]); end
        tests_run++;
        if (rec_cnt[FL+1] !== CW'(1)) begin tests_failed++; $display("FAIL edge_cnt_landed: got %0d want 1", rec_cnt[FL+1]); end
        tests_run++;
        if (rec_tx[FL+1] !== 1'b1) begin tests_failed++; $display("FAIL edge_idle_gap: got %b want 1", rec_tx[FL+1]); end
        tests_run++;
        if (rec_tx[FL+2] !== 1'b0) begin tests_failed++; $display("FAIL edge_next_start: got %b want 0", rec_tx[FL+2]); end
        decode(2*FL + 8);
        tests_run++;
        if (dec_n !== 2) begin tests_failed++; $display("FAIL edge_frames: got %0d want 2", dec_n); end
        tests_run++;
        if (dec_start[1] !== FL + 2) begin tests_failed++; $display("FAIL edge_start1: got %0d want %0d", dec_start[1], FL + 2); end
        tests_run++;
        if (dec_byte[0] !== 8'h81) begin tests_failed++; $display("FAIL edge_byte0: got %h want 81", dec_byte[0]); end
        tests_run++;
        if (dec_byte[1] !== 8'h42) begin tests_failed++; $display("FAIL edge_byte1: got %h want 42", dec_byte[1]); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b [0:5];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        exp_b[3] = 8'h44; exp_b[4] = 8'h55; exp_b[5] = 8'h66;
        clear_stim();
        for (int c = 0; c < 6; c++) begin wr_vld[c] = 1'b1; wr_dat[c] = exp_b[c]; end
        run_stream(5*FL + 8);
        tests_run++;
        if (rec_full[3] !== 1'b0) begin tests_failed++; $display("FAIL ovf_full_early: got %b want 0", rec_full[3]); end
        tests_run++;
        if (rec_full[4] !== 1'b1) begin tests_failed++; $display("FAIL ovf_full_set: got %b want 1", rec_full[4]); end
        tests_run++;
        if (rec_cnt[4] !== CW'(4)) begin tests_failed++; $display("FAIL ovf_cnt_full: got %0d want 4", rec_cnt[4]); end
        tests_run++;
        if (rec_ovf[4] !== 1'b0) begin tests_failed++; $display("FAIL ovf_early: got %b want 0", rec_ovf[4]); end
        tests_run++;
        if (rec_ovf[5] !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got %b want 1", rec_ovf[5]); end
        tests_run++;
        if (rec_cnt[5] !== CW'(4)) begin tests_failed++; $display("FAIL ovf_cnt_drop: got %0d want 4", rec_cnt[5]); end
        tests_run++;
        if (rec_ovf[5*FL+7] !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", rec_ovf[5*FL+7]); end
        decode(5*FL + 8);
        tests_run++;
        if (dec_n !== 5) begin tests_failed++; $display("FAIL ovf_frames: got %0d want 5", dec_n); end
        for (int f = 0; f < 5; f++) begin
            tests_run++;
            if (dec_byte[f] !== exp_b[f]) begin tests_failed++; $display("FAIL ovf_byte%0d: got %h want %h", f, dec_byte[f], exp_b[f]); end
        end
    endtask

    task automatic test_mid_reset();
        // Reset during the start bit, where the line is low.
        clear_stim();
        wr_vld[0] = 1'b1; wr_dat[0] = 8'h55;
        wr_vld[1] = 1'b1; wr_dat[1] = 8'hAA;
        run_stream(3);
        tests_run++;
        if (rec_tx[2] !== 1'b0) begin tests_failed++; $display("FAIL rst_a_start_low: got %b want 0", rec_tx[2]); end
        #3 nReset = 1'b0;
        #1;
        tests_run++;
        if (rs232_tx !== 1'b1) begin tests_failed++; $display("FAIL rst_a_tx_async: got %b want 1", rs232_tx); end
        tests_run++;
        if (fifo_cnt !== '0) begin tests_failed++; $display("FAIL rst_a_cnt: got %0d want 0", fifo_cnt); end
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL rst_a_ovf: got %b want 0", ovf); end
        @(posedge clk50mhz);
        #1 nReset = 1'b1;
        clear_stim();
        run_stream(FL + 10);
        for (int i = 0; i < FL + 10; i++) begin
            tests_run++;
            if ({rec_tx[i], rec_busy[i]} !== 2'b10) begin
                tests_failed++;
                $display("FAIL rst_a_residual%0d: tx=%b busy=%b want tx=1 busy=0", i, rec_tx[i], rec_busy[i]);
            end
        end

        // Reset at cycle 10 of the data phase of 0x55.
        clear_stim();
        wr_vld[0] = 1'b1; wr_dat[0] = 8'h55;
        wr_vld[1] = 1'b1; wr_dat[1] = 8'hAA;
        run_stream(1 + BD + 10);
        tests_run++;
        if (rec_cnt[BD+10] !== CW'(1)) begin tests_failed++; $display("FAIL rst_b_queued: got %0d want 1", rec_cnt[BD+10]); end
        tests_run++;
        if (rec_tx[BD+5] !== 1'b0) begin tests_failed++; $display("FAIL rst_b_data_bit1: got %b want 0", rec_tx[BD+5]); end
        #3 nReset = 1'b0;
        #1;
        tests_run++;
        if (rs232_tx !== 1'b1) begin tests_failed++; $display("FAIL rst_b_tx: got %b want 1", rs232_tx); end
        tests_run++;
        if (fifo_cnt !== '0) begin tests_failed++; $display("FAIL rst_b_cnt: got %0d want 0", fifo_cnt); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_b_busy: got %b want 0", busy); end
        @(posedge clk50mhz);
        #1 nReset = 1'b1;
        clear_stim();
        run_stream(FL + 10);
        for (int i = 0; i < FL + 10; i++) begin
            tests_run++;
            if ({rec_tx[i], rec_busy[i]} !== 2'b10) begin
                tests_failed++;
                $display("FAIL rst_b_residual%0d: tx=%b busy=%b want tx=1 busy=0", i, rec_tx[i], rec_busy[i]);
            end
        end
    endtask

    initial begin
        clear_stim();
        test_reset();
        $display("[TB] reset/idle done, %0d checks so far", tests_run);
        test_single();
        $display("[TB] single write 0xA5 done, %0d checks so far", tests_run);
        test_back_to_back();
        $display("[TB] back-to-back 00/FF/3C done, %0d checks so far", tests_run);
        test_stop_edge_write();
        $display("[TB] write on last stop cycle done, %0d checks so far", tests_run);
        test_overflow();
        $display("[TB] overflow with 6 writes done, %0d checks so far", tests_run);
        test_mid_reset();
        $display("[TB] mid-frame reset done, %0d checks so far", tests_run);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
